// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift engine: operation modes and FSM states.
package shift_pkg;

    typedef enum logic [2:0] {
        ROL = 3'd0,
        ROR = 3'd1,
        LSL = 3'd2,
        LSR = 3'd3,
        ASR = 3'd4
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    // Highest legal mode encoding; anything above passes the operand through.
    localparam shift_mode_t MODE_LAST = ASR;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-position shift/rotate step with the bit that leaves the word.
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] word_i,
    input  shift_mode_t      mode_i,
    output logic [WIDTH-1:0] word_o,
    output logic             bit_o
);

    always_comb begin
        word_o = word_i;
        bit_o  = 1'b0;
        case (mode_i)
            ROL: begin
                word_o = {word_i[WIDTH-2:0], word_i[WIDTH-1]};
                bit_o  = word_i[WIDTH-1];
            end
            ROR: begin
                word_o = {word_i[0], word_i[WIDTH-1:1]};
                bit_o  = word_i[0];
            end
            LSL: begin
                word_o = {word_i[WIDTH-2:0], 1'b0};
                bit_o  = word_i[WIDTH-1];
            end
            LSR: begin
                word_o = {1'b0, word_i[WIDTH-1:1]};
                bit_o  = word_i[0];
            end
            // MSB never changes under ASR, so the current MSB is the original one.
            ASR: begin
                word_o = {word_i[WIDTH-1], word_i[WIDTH-1:1]};
                bit_o  = word_i[0];
            end
            default: begin
                word_o = word_i;
                bit_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Handshaked multi-cycle shift/rotate engine: one bit position per clock,
// result returned with carry (last bit out) and zero flags.
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    import shift_pkg::*;

    shift_state_t     state_q, state_d;
    shift_mode_t      mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] step_word;
    logic             step_bit;

    shift_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .word_i (data_q),
        .mode_i (mode_q),
        .word_o (step_word),
        .bit_o  (step_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= ROL;
            data_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    mode_d  = shift_mode_t'(in_mode);
                    carry_d = 1'b0;
                    if (in_amt == '0 || in_mode > 3'(MODE_LAST)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = in_amt;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d  = step_word;
                carry_d = step_bit;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Zero flag is qualified by DONE so it reads 0 out of reset while data_q is 0.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign out_zero  = (state_q == DONE) && (data_q == '0);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed-vector bench for seq_shift_unit at WIDTH=8 with hand-computed results.
module tb_seq_shift_unit;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_shift_unit #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one request, returns after the accept edge.
    task automatic accept_op(input string tag, input logic [7:0] d, input logic [2:0] a,
                             input logic [2:0] m);
        int t;
        t = 0;
        while (!in_ready && t < 64) begin
            tick();
            t++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        tick();
        in_valid = 1'b0;
    endtask

    // Latency counted with the accept edge as cycle 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_case(input string tag, input logic [7:0] d, input logic [2:0] a,
                            input logic [2:0] m, input logic [7:0] ed, input logic ec,
                            input logic ez, input int elat);
        int lat;
        accept_op(tag, d, a, m);
        wait_valid(lat);
        check({tag, "_lat"},   32'(lat),       32'(elat));
        check({tag, "_data"},  32'(out_data),  32'(ed));
        check({tag, "_carry"}, 32'(out_carry), 32'(ec));
        check({tag, "_zero"},  32'(out_zero),  32'(ez));
        check({tag, "_inrdy"}, 32'(in_ready),  32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdyup"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready_low", 32'(in_ready),  32'd0);
        check("rst_out_valid",    32'(out_valid), 32'd0);
        check("rst_out_data",     32'(out_data),  32'd0);
        check("rst_out_carry",    32'(out_carry), 32'd0);
        check("rst_out_zero",     32'(out_zero),  32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_idle", 32'(in_ready), 32'd1);

        run_case("rol1",  8'h96, 3'd1, 3'd0, 8'h2D, 1'b1, 1'b0, 2);
        run_case("ror3",  8'h96, 3'd3, 3'd1, 8'hD2, 1'b1, 1'b0, 4);
        run_case("asr2",  8'h96, 3'd2, 3'd4, 8'hE5, 1'b1, 1'b0, 3);
        run_case("lsl7",  8'h81, 3'd7, 3'd2, 8'h80, 1'b0, 1'b0, 8);
        run_case("lsr1",  8'h01, 3'd1, 3'd3, 8'h00, 1'b1, 1'b1, 2);
        run_case("amt0",  8'h5A, 3'd0, 3'd2, 8'h5A, 1'b0, 1'b0, 1);
        run_case("mode6", 8'h5A, 3'd3, 3'd6, 8'h5A, 1'b0, 1'b0, 1);
        run_case("ror7",  8'h01, 3'd7, 3'd1, 8'h02, 1'b0, 1'b0, 8);

        // Backpressure: result must hold while a second request waits at the input.
        accept_op("bp", 8'h96, 3'd1, 3'd0);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd2);
        in_valid = 1'b1;
        in_data  = 8'hF0;
        in_amt   = 3'd4;
        in_mode  = 3'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold_data%0d", i),  32'(out_data),  32'h2D);
            check($sformatf("bp_hold_carry%0d", i), 32'(out_carry), 32'd1);
            check($sformatf("bp_hold_rdy%0d", i),   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_hs_vdrop", 32'(out_valid), 32'd0);
        check("bp_hs_rdy",   32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        check("bp2_accepted", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check("bp2_lat",   32'(lat),       32'd5);
        check("bp2_data",  32'(out_data),  32'h00);
        check("bp2_carry", 32'(out_carry), 32'd1);
        check("bp2_zero",  32'(out_zero),  32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset partway through a 6-step LSR discards the operation.
        accept_op("rst_mid", 8'hFF, 3'd6, 3'd3);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_rdy_low", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_data",  32'(out_data),  32'd0);
        check("rst_mid_carry", 32'(out_carry), 32'd0);
        check("rst_mid_zero",  32'(out_zero),  32'd0);
        check("rst_mid_rdy",   32'(in_ready),  32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("rst_mid_no_stale", 32'(seen), 32'd0);

        run_case("post_rst_lsr3", 8'hB4, 3'd3, 3'd3, 8'h16, 1'b1, 1'b0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
